// File: rtl/aes_req_scheduler.sv
// aes_req_scheduler: shares one AES-128 core between two requesters.
// Optional watchdog: define AES_SCHED_WDOG_EN.
//
// Ports:
//   clk, reset              clock (rising), async active-high reset
//   req_valid/req_ready     per-channel job handshake, [0]=ch0 [1]=ch1
//   req_data0/1, req_key0/1 per-channel plaintext and key
//   rsp_valid/rsp_ready     response handshake
//   rsp_tag, rsp_cipher     issuing channel and ciphertext
//   rsp_err                 watchdog abort flag (0 without the watchdog)
//   core_start              one-cycle launch pulse to the core
//   core_data, core_key     operands held stable while the core runs
//   core_done, core_cipher  core completion and its result
module aes_req_scheduler #(
    parameter int DATA_W  = 128,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [DATA_W-1:0] req_data0,
    input  logic [DATA_W-1:0] req_data1,
    input  logic [DATA_W-1:0] req_key0,
    input  logic [DATA_W-1:0] req_key1,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_tag,
    output logic [DATA_W-1:0] rsp_cipher,
    output logic              rsp_err,
    output logic              core_start,
    output logic [DATA_W-1:0] core_data,
    output logic [DATA_W-1:0] core_key,
    input  logic              core_done,
    input  logic [DATA_W-1:0] core_cipher
);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT,
        RESP
    } state_t;

    state_t state;
    state_t state_nxt;

    logic rr_last;
    logic grant;
    logic take;
    logic capture;
    logic wdog_hit;

    // On a tie the channel that did not win last time goes next;
    // otherwise the single requesting channel wins.
    always_comb begin
        grant = req_valid[1];
        if (&req_valid) begin
            grant = ~rr_last;
        end
    end

`ifdef AES_SCHED_WDOG_EN
    logic [7:0] wdog_cnt;
    logic       err_q;

    // Fires on the WAIT cycle whose increment would reach TIMEOUT,
    // so the abort response appears TIMEOUT+1 cycles after launch.
    assign wdog_hit = (state == WAIT) &&
                      (wdog_cnt == 8'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wdog_cnt <= 8'd0;
        end else if (state == LAUNCH) begin
            wdog_cnt <= 8'd0;
        end else if (state == WAIT) begin
            wdog_cnt <= wdog_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (capture) begin
            err_q <= 1'b0;
        end else if (wdog_hit) begin
            err_q <= 1'b1;
        end
    end

    assign rsp_err = err_q;
`else
    assign wdog_hit = 1'b0;
    assign rsp_err  = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = 2'b00;
        core_start = 1'b0;
        rsp_valid  = 1'b0;
        take       = 1'b0;
        capture    = 1'b0;
        unique case (state)
            IDLE: begin
                // Reset gating keeps req_ready low while reset is held.
                if ((|req_valid) && !reset) begin
                    take             = 1'b1;
                    req_ready[grant] = 1'b1;
                    state_nxt        = LAUNCH;
                end
            end
            LAUNCH: begin
                core_start = 1'b1;
                state_nxt  = WAIT;
            end
            WAIT: begin
                // core_done on the timeout cycle still wins.
                if (core_done) begin
                    capture   = 1'b1;
                    state_nxt = RESP;
                end else if (wdog_hit) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_last   <= 1'b1;
            rsp_tag   <= 1'b0;
            core_data <= '0;
            core_key  <= '0;
        end else if (take) begin
            rr_last   <= grant;
            rsp_tag   <= grant;
            core_data <= grant ? req_data1 : req_data0;
            core_key  <= grant ? req_key1  : req_key0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_cipher <= '0;
        end else if (capture) begin
            rsp_cipher <= core_cipher;
        end else if (wdog_hit) begin
            rsp_cipher <= '0;
        end
    end

endmodule

// File: tb/tb_aes_req_scheduler.sv
// Directed bench for aes_req_scheduler with a behavioural core model.
// Watchdog cases run only when AES_SCHED_WDOG_EN is defined.
module tb_aes_req_scheduler;

    localparam logic [127:0] FIPS_KEY =
        128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT =
        128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT =
        128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [1:0]   req_valid = 2'b00;
    logic [1:0]   req_ready;
    logic [127:0] req_data0 = '0;
    logic [127:0] req_data1 = '0;
    logic [127:0] req_key0 = '0;
    logic [127:0] req_key1 = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b1;
    logic         rsp_tag;
    logic [127:0] rsp_cipher;
    logic         rsp_err;
    logic         core_start;
    logic [127:0] core_data;
    logic [127:0] core_key;
    logic         core_done;
    logic [127:0] core_cipher;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    aes_req_scheduler #(
        .DATA_W (128),
        .TIMEOUT(64)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_data0  (req_data0),
        .req_data1  (req_data1),
        .req_key0   (req_key0),
        .req_key1   (req_key1),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_tag    (rsp_tag),
        .rsp_cipher (rsp_cipher),
        .rsp_err    (rsp_err),
        .core_start (core_start),
        .core_data  (core_data),
        .core_key   (core_key),
        .core_done  (core_done),
        .core_cipher(core_cipher)
    );

    // Core model: FIPS-197 vector is exact, anything else uses
    // a simple keyed mix so each channel's result is distinct.
    function automatic logic [127:0] aes_model(
        input logic [127:0] d,
        input logic [127:0] k
    );
        if (d == FIPS_PT && k == FIPS_KEY) return FIPS_CT;
        return d ^ {k[63:0], k[127:64]} ^ {4{32'h5a5ac3c3}};
    endfunction

    logic         m_done = 1'b0;
    logic         m_busy = 1'b0;
    logic         spur = 1'b0;
    logic         hang = 1'b0;
    logic [2:0]   m_cnt = 3'd0;
    logic [127:0] m_d = '0;
    logic [127:0] m_k = '0;
    logic [127:0] m_c = '0;

    assign core_done   = m_done | spur;
    assign core_cipher = m_done ? m_c : {4{32'hdeadbeef}};

    always @(posedge clk) begin
        m_done <= 1'b0;
        if (core_start && !hang) begin
            m_busy <= 1'b1;
            m_cnt  <= 3'd0;
            m_d    <= core_data;
            m_k    <= core_key;
        end else if (m_busy) begin
            if (m_cnt == 3'd3) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
                m_c    <= aes_model(m_d, m_k);
            end else begin
                m_cnt <= m_cnt + 3'd1;
            end
        end
    end

    task automatic check(
        input string        tag,
        input logic [127:0] got,
        input logic [127:0] exp
    );
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive_req(
        input int           ch,
        input logic [127:0] d,
        input logic [127:0] k
    );
        if (ch == 1) begin
            req_data1 = d;
            req_key1  = k;
        end else begin
            req_data0 = d;
            req_key0  = k;
        end
        req_valid[ch] = 1'b1;
    endtask

    task automatic wait_ready(input string tag, input int ch);
        int n;
        logic [1:0] oh;
        oh = (ch == 1) ? 2'b10 : 2'b01;
        n = 0;
        while (req_ready == 2'b00 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_grant"}, 128'(req_ready), 128'(oh));
    endtask

    task automatic do_job(
        input int           ch,
        input logic [127:0] d,
        input logic [127:0] k,
        input logic [127:0] exp_c,
        input string        tag
    );
        int n;
        @(negedge clk);
        rsp_ready = 1'b1;
        drive_req(ch, d, k);
        #1;
        wait_ready(tag, ch);
        @(negedge clk);
        req_valid[ch] = 1'b0;
        check({tag, "_start"}, 128'(core_start), 128'd1);
        n = 0;
        while (!core_done && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done"}, 128'(core_done), 128'd1);
        @(negedge clk);
        check({tag, "_rsp_lat"}, 128'(rsp_valid), 128'd1);
        check({tag, "_tag"}, 128'(rsp_tag), 128'(ch));
        check({tag, "_cipher"}, rsp_cipher, exp_c);
        check({tag, "_err"}, 128'(rsp_err), 128'd0);
        @(negedge clk);
        check({tag, "_rsp_drop"}, 128'(rsp_valid), 128'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int n;
        int bad;
        logic         s_tag;
        logic [127:0] s_c;
        logic [127:0] d0;
        logic [127:0] d1;
        logic [127:0] k0;
        logic [127:0] k1;

        d0 = 128'h0123456789abcdeffedcba9876543210;
        k0 = 128'h11112222333344445555666677778888;
        d1 = 128'hcafef00ddeadbeef0badc0de12345678;
        k1 = 128'h99990000aaaabbbbccccddddeeeeffff;

        // Both channels requesting while reset is still held.
        req_data0 = d0;
        req_key0  = k0;
        req_data1 = d1;
        req_key1  = k1;
        req_valid = 2'b11;
        repeat (3) @(negedge clk);
        #1;
        check("rst_req_ready", 128'(req_ready), 128'd0);
        check("rst_rsp_valid", 128'(rsp_valid), 128'd0);
        check("rst_core_start", 128'(core_start), 128'd0);
        check("rst_core_data", core_data, 128'd0);
        check("rst_rsp_cipher", rsp_cipher, 128'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) begin
            n = 0;
            while (req_ready == 2'b00 && n < 50) begin
                @(negedge clk);
                n++;
            end
            check($sformatf("rr%0d_grant", i), 128'(req_ready),
                  (i % 2 == 0) ? 128'd1 : 128'd2);
            n = 0;
            while (!rsp_valid && n < 50) begin
                @(negedge clk);
                n++;
            end
            check($sformatf("rr%0d_tag", i), 128'(rsp_tag),
                  128'(i % 2));
            check($sformatf("rr%0d_cipher", i), rsp_cipher,
                  (i % 2 == 0) ? aes_model(d0, k0)
                               : aes_model(d1, k1));
            @(negedge clk);
        end
        req_valid = 2'b00;
        repeat (12) @(negedge clk);

        // FIPS-197 vector on ch0.
        do_job(0, FIPS_PT, FIPS_KEY, FIPS_CT, "fips");

        // Response back-pressure with ch1 waiting.
        @(negedge clk);
        rsp_ready = 1'b0;
        drive_req(0, d0, k0);
        #1;
        wait_ready("hold", 0);
        @(negedge clk);
        req_valid = 2'b10;
        n = 0;
        while (!rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("hold_valid", 128'(rsp_valid), 128'd1);
        s_tag = rsp_tag;
        s_c   = rsp_cipher;
        check("hold_cipher", s_c, aes_model(d0, k0));
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_tag !== s_tag ||
                rsp_cipher !== s_c || req_ready !== 2'b00 ||
                core_start !== 1'b0)
                bad++;
        end
        check("hold_stable", 128'(bad), 128'd0);
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("hold_release", 128'(rsp_valid), 128'd0);
        repeat (8) @(negedge clk);

        // Reset in the middle of a job.
        drive_req(0, d0, k0);
        #1;
        wait_ready("midrst", 0);
        @(negedge clk);
        req_valid = 2'b00;
        check("midrst_start", 128'(core_start), 128'd1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_rsp_valid", 128'(rsp_valid), 128'd0);
        check("midrst_core_data", core_data, 128'd0);
        check("midrst_core_key", core_key, 128'd0);
        check("midrst_tag_err", {rsp_tag, rsp_err, core_start},
              128'd0);
        @(negedge clk);
        reset = 1'b0;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || core_start !== 1'b0) bad++;
        end
        check("midrst_discard", 128'(bad), 128'd0);
        do_job(1, d1, k1, aes_model(d1, k1), "postrst");

        // Stray core_done while idle.
        @(negedge clk);
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        bad = 0;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || core_start !== 1'b0) bad++;
        end
        check("spur_ignored", 128'(bad), 128'd0);
        do_job(0, FIPS_PT, FIPS_KEY, FIPS_CT, "spur_job");

`ifdef AES_SCHED_WDOG_EN
        // Core that never finishes.
        @(negedge clk);
        hang = 1'b1;
        drive_req(1, d1, k1);
        #1;
        wait_ready("wdog", 1);
        @(negedge clk);
        req_valid = 2'b00;
        check("wdog_start", 128'(core_start), 128'd1);
        n = 0;
        while (!rsp_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("wdog_lat", 128'(n), 128'd65);
        check("wdog_err", 128'(rsp_err), 128'd1);
        check("wdog_cipher", rsp_cipher, 128'd0);
        check("wdog_tag", 128'(rsp_tag), 128'd1);
        @(negedge clk);
        hang = 1'b0;
        repeat (4) @(negedge clk);
        do_job(0, d0, k0, aes_model(d0, k0), "wdog_after");
`endif

        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
